// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up sequencer: waits, PRECHARGE ALL, N x AUTO REFRESH, MODE REGISTER SET,
// then stays resident to service run-time mode reprogramming and full re-initialisation.
module sdram_init_ctrl #(
  parameter int CLOCK_MHZ  = 100,
  parameter int POWERUP_NS = 200000,
  parameter int TRP_NS     = 20,
  parameter int TRC_NS     = 70,
  parameter int TMRD_CYC   = 2,
  parameter int REF_COUNT  = 8,
  parameter int ADDR_W     = 13,
  parameter int BA_W       = 2,
  parameter int DQM_W      = 4,
  parameter int INIT_CL    = 3,
  parameter int INIT_BT    = 1,
  parameter int INIT_BL    = 4,
  parameter int INIT_WB    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mrs_req,
  input  logic [2:0]        mrs_cl,
  input  logic              mrs_bt,
  input  logic              mrs_wb,
  input  logic [2:0]        mrs_bl,
  input  logic              reinit_req,
  output logic              initiated,
  output logic              mode_ack,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic              DRAM_CKE,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic [DQM_W-1:0]  DRAM_DQM
);

  function automatic int ns_to_cyc(input longint ns);
    longint c;
    c = (ns * longint'(CLOCK_MHZ) + 64'sd999) / 64'sd1000;
    return (c < 64'sd1) ? 32'sd1 : int'(c);
  endfunction

  function automatic logic [2:0] bl_code(input int bl);
    case (bl)
      32'sd1:  return 3'b000;
      32'sd2:  return 3'b001;
      32'sd4:  return 3'b010;
      32'sd8:  return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] mode_word(input logic wb, input logic [2:0] cl,
                                                   input logic bt, input logic [2:0] bl);
    logic [ADDR_W-1:0] w;
    w      = '0;
    w[9]   = wb;
    w[6:4] = cl;
    w[3]   = bt;
    w[2:0] = bl;
    return w;
  endfunction

  localparam int POWERUP_CYC = ns_to_cyc(longint'(POWERUP_NS));
  localparam int TRP_CYC     = ns_to_cyc(longint'(TRP_NS));
  localparam int TRC_CYC     = ns_to_cyc(longint'(TRC_NS));
  localparam int TMRD_C      = (TMRD_CYC < 32'sd1) ? 32'sd1 : TMRD_CYC;
  localparam int CNT_W       = $clog2(POWERUP_CYC + 32'sd1);
  localparam int REF_W       = $clog2(REF_COUNT + 32'sd1);

  // Wait states hold for (spacing - 1) cycles, so the timer is loaded with spacing - 2.
  localparam logic [CNT_W-1:0] PU_LD   = CNT_W'(POWERUP_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'((TRP_CYC > 32'sd1) ? TRP_CYC - 32'sd2 : 32'sd0);
  localparam logic [CNT_W-1:0] TRC_LD  = CNT_W'((TRC_CYC > 32'sd1) ? TRC_CYC - 32'sd2 : 32'sd0);
  localparam logic [CNT_W-1:0] TMRD_LD = CNT_W'((TMRD_C > 32'sd1) ? TMRD_C - 32'sd2 : 32'sd0);
  localparam logic [REF_W-1:0] REF_N   = REF_W'(REF_COUNT);
  localparam logic [REF_W-1:0] REF_ONE = REF_W'(32'sd1);

  localparam logic [ADDR_W-1:0] PALL_ADDR = ADDR_W'(11'h400);
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PALL = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  localparam logic [2:0] INIT_CL_V = 3'(INIT_CL);
  localparam logic       INIT_BT_V = 1'(INIT_BT);
  localparam logic       INIT_WB_V = 1'(INIT_WB);
  localparam logic [2:0] INIT_BL_V = bl_code(INIT_BL);

  typedef enum logic [2:0] {
    ST_POWERUP, ST_PALL, ST_WAIT_RP, ST_REF, ST_WAIT_RC, ST_MRS, ST_WAIT_MRD, ST_READY
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [REF_W-1:0] ref_cnt_r, ref_cnt_s;
  logic             full_seq_r, full_seq_s;
  logic             ack_pend_r, ack_pend_s;
  logic             latch_s;
  logic [2:0]       cl_r, bl_r;
  logic             bt_r, wb_r;

  // Sequencer state, wait timer, refresh count and request bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_POWERUP;
      cnt_r      <= PU_LD;
      ref_cnt_r  <= '0;
      full_seq_r <= 1'b1;
      ack_pend_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      ref_cnt_r  <= ref_cnt_s;
      full_seq_r <= full_seq_s;
      ack_pend_r <= ack_pend_s;
    end
  end

  // Mode latch: power-up fields on reset, request fields when a request is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cl_r <= INIT_CL_V;
      bt_r <= INIT_BT_V;
      wb_r <= INIT_WB_V;
      bl_r <= INIT_BL_V;
    end else if (latch_s) begin
      cl_r <= mrs_cl;
      bt_r <= mrs_bt;
      wb_r <= mrs_wb;
      bl_r <= mrs_bl;
    end else begin
      cl_r <= cl_r;
      bt_r <= bt_r;
      wb_r <= wb_r;
      bl_r <= bl_r;
    end
  end

  // Next-state logic; a spacing of one cycle skips its wait state entirely
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ref_cnt_s  = ref_cnt_r;
    full_seq_s = full_seq_r;
    ack_pend_s = ack_pend_r;
    latch_s    = 1'b0;
    case (state_r)
      ST_POWERUP: begin
        if (cnt_r == '0) begin
          state_s   = ST_PALL;
          ref_cnt_s = '0;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_PALL: begin
        if (TRP_CYC > 32'sd1) begin
          state_s = ST_WAIT_RP;
          cnt_s   = TRP_LD;
        end else begin
          state_s = full_seq_r ? ST_REF : ST_MRS;
        end
      end
      ST_WAIT_RP: begin
        if (cnt_r == '0) begin
          state_s = full_seq_r ? ST_REF : ST_MRS;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_REF: begin
        ref_cnt_s = ref_cnt_r + REF_ONE;
        if (TRC_CYC > 32'sd1) begin
          state_s = ST_WAIT_RC;
          cnt_s   = TRC_LD;
        end else begin
          state_s = ((ref_cnt_r + REF_ONE) < REF_N) ? ST_REF : ST_MRS;
        end
      end
      ST_WAIT_RC: begin
        if (cnt_r == '0) begin
          state_s = (ref_cnt_r < REF_N) ? ST_REF : ST_MRS;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_MRS: begin
        if (TMRD_C > 32'sd1) begin
          state_s = ST_WAIT_MRD;
          cnt_s   = TMRD_LD;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_WAIT_MRD: begin
        if (cnt_r == '0) begin
          state_s = ST_READY;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_READY: begin
        // Any pending ack is emitted this cycle; a new one is owed only for a new mrs_req.
        ack_pend_s = mrs_req;
        if (reinit_req || mrs_req) begin
          state_s    = ST_PALL;
          ref_cnt_s  = '0;
          full_seq_s = reinit_req;
          latch_s    = mrs_req;
        end else begin
          state_s = ST_READY;
        end
      end
      default: begin
        state_s = ST_POWERUP;
        cnt_s   = PU_LD;
      end
    endcase
  end

  // Registered pin decode: each command state drives its command for exactly one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_NOP;
      DRAM_ADDR <= '0;
      DRAM_BA   <= '0;
      DRAM_CKE  <= 1'b1;
      DRAM_CS_N <= 1'b0;
      DRAM_DQM  <= '1;
      initiated <= 1'b0;
      mode_ack  <= 1'b0;
    end else begin
      DRAM_BA   <= '0;
      DRAM_CKE  <= 1'b1;
      DRAM_CS_N <= 1'b0;
      DRAM_DQM  <= '1;
      initiated <= (state_r == ST_READY);
      mode_ack  <= (state_r == ST_READY) && ack_pend_r;
      case (state_r)
        ST_PALL: begin
          {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_PALL;
          DRAM_ADDR <= PALL_ADDR;
        end
        ST_REF: begin
          {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_REF;
          DRAM_ADDR <= '0;
        end
        ST_MRS: begin
          {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_MRS;
          DRAM_ADDR <= mode_word(wb_r, cl_r, bt_r, bl_r);
        end
        default: begin
          {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_NOP;
          DRAM_ADDR <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Scoreboard bench: two sequencers (100 MHz/2 refreshes and 133 MHz/8 refreshes) checked
// against expected command/initiated/ack timelines built from the timing rules.
`timescale 1ns/1ps
module tb_sdram_init_ctrl;
  localparam int AW = 13;
  localparam logic [2:0] C_NOP = 3'b111, C_PALL = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
  localparam int INIT_MODE = 58;  // WB=0, CL=3, BT=1, BL=4 -> 0x03A

  typedef struct { int cyc; logic [2:0] cmd; logic [AW-1:0] addr; } ev_t;

  logic clock = 1'b0;
  logic reset, reset_b, mrs_req, reinit_req, mrs_bt, mrs_wb;
  logic [2:0] mrs_cl, mrs_bl;
  logic initiated, mode_ack, cke, cs_n, ras_n, cas_n, we_n;
  logic [AW-1:0] addr;
  logic [1:0] ba;
  logic [3:0] dqm;
  logic initiated_b, mode_ack_b, cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b;
  logic [AW-1:0] addr_b;
  logic [1:0] ba_b;
  logic [3:0] dqm_b;
  logic zero1 = 1'b0;
  logic [2:0] zero3 = 3'b000;

  int tests = 0, fails = 0;
  int cyc_a = -1, cyc_b = -1;
  int rise_a = 0, mode_a = INIT_MODE;
  logic init_prev_a = 1'b0, init_prev_b = 1'b0;
  ev_t qc_a[$], qc_b[$];
  int qi_a[$], qi_b[$], qk_a[$], qk_b[$];

  always #5 clock = ~clock;

  sdram_init_ctrl #(.CLOCK_MHZ(100), .POWERUP_NS(1000), .TRP_NS(20), .TRC_NS(70),
                    .TMRD_CYC(2), .REF_COUNT(2)) dut (
    .clock(clock), .reset(reset), .mrs_req(mrs_req), .mrs_cl(mrs_cl), .mrs_bt(mrs_bt),
    .mrs_wb(mrs_wb), .mrs_bl(mrs_bl), .reinit_req(reinit_req), .initiated(initiated),
    .mode_ack(mode_ack), .DRAM_ADDR(addr), .DRAM_BA(ba), .DRAM_CKE(cke), .DRAM_CS_N(cs_n),
    .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n), .DRAM_DQM(dqm));

  sdram_init_ctrl #(.CLOCK_MHZ(133), .POWERUP_NS(1000), .REF_COUNT(8)) dut_b (
    .clock(clock), .reset(reset_b), .mrs_req(zero1), .mrs_cl(zero3), .mrs_bt(zero1),
    .mrs_wb(zero1), .mrs_bl(zero3), .reinit_req(zero1), .initiated(initiated_b),
    .mode_ack(mode_ack_b), .DRAM_ADDR(addr_b), .DRAM_BA(ba_b), .DRAM_CKE(cke_b),
    .DRAM_CS_N(cs_n_b), .DRAM_RAS_N(ras_n_b), .DRAM_CAS_N(cas_n_b), .DRAM_WE_N(we_n_b),
    .DRAM_DQM(dqm_b));

  task automatic check(input bit ok, input string name, input string detail);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Cycle 0 is the first rising edge after reset release.
  always @(posedge clock or posedge reset) cyc_a <= reset ? -1 : cyc_a + 1;
  always @(posedge clock or posedge reset_b) cyc_b <= reset_b ? -1 : cyc_b + 1;

  task automatic push_cmd(input int w, input int c, input logic [2:0] cmd, input logic [AW-1:0] a);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.addr = a;
    if (w == 0) qc_a.push_back(e);
    else qc_b.push_back(e);
  endtask

  // Reference timeline: PALL, then tRP, then REFs tRC apart, MRS, then tMRD to initiated.
  task automatic push_seq(input int w, input int start, input bit full, input int mode, input bit ack);
    int trp, trc, nref, t;
    trp  = (w == 0) ? 2 : 3;
    trc  = (w == 0) ? 7 : 10;
    nref = (w == 0) ? 2 : 8;
    push_cmd(w, start, C_PALL, 13'h400);
    t = start + trp;
    if (full) begin
      for (int i = 0; i < nref; i++) begin
        push_cmd(w, t, C_REF, 13'h000);
        t = t + trc;
      end
    end
    push_cmd(w, t, C_MRS, AW'(mode));
    t = t + 2;
    if (w == 0) begin
      qi_a.push_back(t);
      if (ack) qk_a.push_back(t);
      rise_a = t;
    end else begin
      qi_b.push_back(t);
    end
  endtask

  task automatic sample(input int w, input int c, input logic [2:0] cmd, input logic [AW-1:0] a,
                        input logic [1:0] b, input logic k, input logic cs, input logic [3:0] dm,
                        input logic ini, input logic ini_prev, input logic ack);
    ev_t e;
    int t;
    bit have;
    if (cmd != C_NOP) begin
      have = 1'b0;
      if (w == 0 && qc_a.size() > 0) begin e = qc_a.pop_front(); have = 1'b1; end
      else if (w == 1 && qc_b.size() > 0) begin e = qc_b.pop_front(); have = 1'b1; end
      if (!have)
        check(1'b0, "unexpected_cmd", $sformatf("dut%0d cycle %0d got cmd %b, required NOP", w, c, cmd));
      else
        check(e.cyc == c && e.cmd == cmd && e.addr == a && b == 2'b00 && k && !cs && dm == 4'hF && !ini,
              "command", $sformatf("dut%0d got cycle %0d cmd %b addr %h ba %h cke %b cs_n %b dqm %h init %b; required cycle %0d cmd %b addr %h ba 0 cke 1 cs_n 0 dqm f init 0",
              w, c, cmd, a, b, k, cs, dm, ini, e.cyc, e.cmd, e.addr));
    end
    if (ini && !ini_prev) begin
      have = 1'b0;
      if (w == 0 && qi_a.size() > 0) begin t = qi_a.pop_front(); have = 1'b1; end
      else if (w == 1 && qi_b.size() > 0) begin t = qi_b.pop_front(); have = 1'b1; end
      if (!have) check(1'b0, "unexpected_init", $sformatf("dut%0d initiated rose at cycle %0d, required none", w, c));
      else check(t == c, "init_rise", $sformatf("dut%0d got rise at cycle %0d, required %0d", w, c, t));
    end
    if (!ini && ini_prev && cmd != C_PALL)
      check(1'b0, "init_fall", $sformatf("dut%0d initiated fell at cycle %0d with cmd %b, required fall with PALL", w, c, cmd));
    if (ack) begin
      have = 1'b0;
      if (w == 0 && qk_a.size() > 0) begin t = qk_a.pop_front(); have = 1'b1; end
      else if (w == 1 && qk_b.size() > 0) begin t = qk_b.pop_front(); have = 1'b1; end
      if (!have) check(1'b0, "unexpected_ack", $sformatf("dut%0d mode_ack at cycle %0d, required none", w, c));
      else check(t == c, "mode_ack", $sformatf("dut%0d got ack at cycle %0d, required %0d", w, c, t));
    end
  endtask

  // Monitors: outputs sampled on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (!reset) sample(0, cyc_a, {ras_n, cas_n, we_n}, addr, ba, cke, cs_n, dqm, initiated, init_prev_a, mode_ack);
    init_prev_a <= reset ? 1'b0 : initiated;
  end

  always @(negedge clock) begin
    if (!reset_b) sample(1, cyc_b, {ras_n_b, cas_n_b, we_n_b}, addr_b, ba_b, cke_b, cs_n_b, dqm_b, initiated_b, init_prev_b, mode_ack_b);
    init_prev_b <= reset_b ? 1'b0 : initiated_b;
  end

  task automatic check_rst(input string name, input logic [2:0] cmd, input logic [AW-1:0] a,
                           input logic [1:0] b, input logic k, input logic cs, input logic [3:0] dm,
                           input logic ini, input logic ack);
    check(cmd == C_NOP && a == '0 && b == 2'b00 && k && !cs && dm == 4'hF && !ini && !ack, name,
          $sformatf("got cmd %b addr %h ba %h cke %b cs_n %b dqm %h init %b ack %b; required cmd 111 addr 0 ba 0 cke 1 cs_n 0 dqm f init 0 ack 0",
          cmd, a, b, k, cs, dm, ini, ack));
  endtask

  task automatic wait_a(input int c);
    int guard = 0;
    while (cyc_a < c && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 5000) check(1'b0, "wait_timeout", $sformatf("cycle %0d, required reaching %0d", cyc_a, c));
  endtask

  // Drive one request for one cycle; the model accepts it only if initiated is already high.
  task automatic issue(input bit do_mrs, input bit do_reinit, input logic [2:0] cl, input logic bt,
                       input logic [2:0] bl, input logic wb);
    int c;
    c = cyc_a;
    mrs_req = do_mrs; reinit_req = do_reinit;
    mrs_cl = cl; mrs_bt = bt; mrs_bl = bl; mrs_wb = wb;
    if (c >= rise_a && (do_mrs || do_reinit)) begin
      if (do_mrs) mode_a = int'(wb) * 512 + int'(cl) * 16 + int'(bt) * 8 + int'(bl);
      push_seq(0, c + 2, do_reinit, mode_a, do_mrs);
    end
    @(negedge clock);
    mrs_req = 1'b0; reinit_req = 1'b0;
  endtask

  task automatic flush_a(input int now);
    int missed = 0;
    foreach (qc_a[i]) if (qc_a[i].cyc <= now) missed++;
    foreach (qi_a[i]) if (qi_a[i] <= now) missed++;
    foreach (qk_a[i]) if (qk_a[i] <= now) missed++;
    check(missed == 0, "due_before_reset", $sformatf("got %0d unserved expectations at cycle %0d, required 0", missed, now));
    qc_a.delete(); qi_a.delete(); qk_a.delete();
  endtask

  task automatic reset_a_and_release();
    int now;
    now = cyc_a;
    #2;
    flush_a(now);
    reset = 1'b1;
    #1;
    check_rst("async_reset", {ras_n, cas_n, we_n}, addr, ba, cke, cs_n, dqm, initiated, mode_ack);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mode_a = INIT_MODE;
    push_seq(0, 100, 1'b1, INIT_MODE, 1'b0);
  endtask

  initial begin
    int k;
    reset = 1'b1; reset_b = 1'b1; mrs_req = 1'b0; reinit_req = 1'b0;
    mrs_cl = 3'd0; mrs_bt = 1'b0; mrs_bl = 3'd0; mrs_wb = 1'b0;
    repeat (3) @(negedge clock);
    check_rst("reset_hold_a", {ras_n, cas_n, we_n}, addr, ba, cke, cs_n, dqm, initiated, mode_ack);
    check_rst("reset_hold_b", {ras_n_b, cas_n_b, we_n_b}, addr_b, ba_b, cke_b, cs_n_b, dqm_b, initiated_b, mode_ack_b);
    reset = 1'b0; reset_b = 1'b0;
    rise_a = 1 << 30;
    push_seq(0, 100, 1'b1, INIT_MODE, 1'b0);
    push_seq(1, 133, 1'b1, INIT_MODE, 1'b0);
    wait_a(0);
    check_rst("after_release", {ras_n, cas_n, we_n}, addr, ba, cke, cs_n, dqm, initiated, mode_ack);
    // Request during power-up must be ignored.
    wait_a(49);
    issue(1'b1, 1'b0, 3'd2, 1'b0, 3'd3, 1'b1);
    // Reset in the middle of the refresh phase.
    wait_a(105);
    reset_a_and_release();
    wait_a(rise_a);
    issue(1'b1, 1'b0, 3'd2, 1'b0, 3'd3, 1'b1);  // expect MRS 0x223
    wait_a(rise_a);
    issue(1'b1, 1'b1, 3'd2, 1'b0, 3'd1, 1'b0);  // reinit wins, MRS 0x021, single ack
    wait_a(rise_a);
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(3, 1);
      issue(k[0], k[1], 3'($urandom_range(3, 2)), 1'($urandom_range(1, 0)),
            3'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      k = $urandom_range(rise_a - 2, cyc_a + 1);
      wait_a(k);
      issue(1'b1, 1'($urandom_range(1, 0)), 3'($urandom_range(3, 2)), 1'($urandom_range(1, 0)),
            3'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      wait_a(rise_a + $urandom_range(4, 0));
    end
    // Reset after run-time changes: the power-up mode must be reloaded.
    wait_a(rise_a + 2);
    reset_a_and_release();
    wait_a(rise_a + 3);
    check(qc_a.size() == 0 && qi_a.size() == 0 && qk_a.size() == 0, "drain_a",
          $sformatf("got %0d/%0d/%0d pending cmd/init/ack, required 0/0/0", qc_a.size(), qi_a.size(), qk_a.size()));
    check(qc_b.size() == 0 && qi_b.size() == 0, "drain_b",
          $sformatf("got %0d/%0d pending cmd/init, required 0/0", qc_b.size(), qi_b.size()));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1);
  end

endmodule
